// File: rtl/round_sequencer.sv
// round_sequencer: game-round controller that requests targets, times guess windows and scores hits
module round_sequencer #(
   parameter int COORD_W = 5,
   parameter int ROUNDS  = 8,
   parameter int TIMEOUT = 1000,
   parameter int SCORE_W = 4,
   localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               guess_valid,
   input  logic [COORD_W-1:0] guess_x,
   input  logic [COORD_W-1:0] guess_y,
   input  logic [COORD_W-1:0] target_x,
   input  logic [COORD_W-1:0] target_y,
   output logic               new_target,
   output logic               busy,
   output logic               hit,
   output logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic [RW-1:0]      round_idx,
   output logic               game_over
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL, S_DONE} state_t;
   state_t state, next;
   logic [TW-1:0] timer;
   logic [COORD_W-1:0] gx, gy;
   logic timed_out, match, last_round, idle;
   assign idle = state == S_IDLE || state == S_DONE;
   assign last_round = round_idx == RW'(ROUNDS - 1);
   assign match = !timed_out && gx == target_x && gy == target_y;
   always_ff @(posedge clk)
      state <= !reset_n ? S_IDLE : next;
   always_comb begin
      next = idle ? (start ? S_REQ : state) :
             state == S_REQ  ? S_WAIT :
             state == S_WAIT ? ((guess_valid || timer == TW'(TIMEOUT - 1)) ? S_EVAL : S_WAIT) :
             state == S_EVAL ? (last_round ? S_DONE : S_REQ) :
             S_IDLE;
   end
   always_comb begin
      new_target = state == S_REQ;
      busy       = state == S_REQ || state == S_WAIT || state == S_EVAL;
      hit        = state == S_EVAL && match;
      miss       = state == S_EVAL && !match;
      game_over  = state == S_DONE;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         timer     <= '0;
         gx        <= '0;
         gy        <= '0;
         timed_out <= 1'b0;
         score     <= '0;
         round_idx <= '0;
      end else begin
         timer <= (state == S_WAIT) ? timer + 1'b1 : '0;
         // the final WAIT cycle's capture is what EVAL sees: a guess there beats the timeout
         if (state == S_WAIT) begin
            gx        <= guess_x;
            gy        <= guess_y;
            timed_out <= !guess_valid;
         end
         if (idle && start) begin
            score     <= '0;
            round_idx <= '0;
         end else if (state == S_EVAL) begin
            score     <= (match && score != '1) ? score + 1'b1 : score;
            round_idx <= last_round ? round_idx : round_idx + 1'b1;
         end
      end
   end
endmodule
